// File: rtl/ecm_k_streamer.sv
// Streams the scalar k to the Montgomery ladder MSB-first, skipping leading zeros and the leading 1.
// Optional one-word read-ahead enabled by defining ECM_K_PREFETCH_EN.
module ecm_k_streamer #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  k_len_words,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [WORD_WIDTH-1:0] mem_rd_data,
   input  logic                  mem_rd_val,
   input  logic                  k_req,
   output logic                  k_val,
   output logic                  k_bit,
   output logic                  k_last
);

   localparam int BC_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(WORD_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SCAN, STREAM, DONE} state_t;

   state_t                  state_q, state_d;
   logic [WORD_WIDTH-1:0]   sr_q, sr_d;
   logic [BC_W-1:0]         bc_q, bc_d;
   logic [LEN_WIDTH-1:0]    wi_q, wi_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    found_q, found_d;
   logic                    err_q, err_d;
   logic                    rd_en_q, rd_en_d;
   logic                    sr_msb, bc_zero, wi_zero, xfer;

`ifdef ECM_K_PREFETCH_EN
   logic [WORD_WIDTH-1:0]   pf_q, pf_d;
   logic                    pf_full_q, pf_full_d;
   logic                    pf_pend_q, pf_pend_d;
   logic                    pf_issue;
`endif

   assign sr_msb  = sr_q[WORD_WIDTH-1];
   assign bc_zero = (bc_q == '0);
   assign wi_zero = (wi_q == '0);
   assign xfer    = (state_q == STREAM) && k_req;

`ifdef ECM_K_PREFETCH_EN
   // Read ahead only while streaming and never on the cycle that crosses a word boundary.
   assign pf_issue = (state_q == STREAM) && !wi_zero && !pf_full_q && !pf_pend_q &&
                     !(xfer && bc_zero);
`endif

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bc_d    = bc_q;
      wi_d    = wi_q;
      addr_d  = addr_q;
      found_d = found_q;
      err_d   = err_q;
`ifdef ECM_K_PREFETCH_EN
      pf_d      = pf_q;
      pf_full_d = pf_full_q;
      pf_pend_d = pf_pend_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               found_d = 1'b0;
               wi_d    = k_len_words - LEN_WIDTH'(1);
               addr_d  = base_addr + ADDR_WIDTH'(k_len_words) - ADDR_WIDTH'(1);
               if (k_len_words == '0) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         RD_REQ: state_d = RD_WAIT;
         RD_WAIT: begin
            if (mem_rd_val) begin
               sr_d    = mem_rd_data;
               bc_d    = BC_MAX;
               state_d = found_q ? STREAM : SCAN;
`ifdef ECM_K_PREFETCH_EN
               pf_pend_d = 1'b0;
`endif
            end
         end
         SCAN: begin
            sr_d = {sr_q[WORD_WIDTH-2:0], 1'b0};
            if (sr_msb) found_d = 1'b1;
            if (bc_zero) begin
               if (wi_zero) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  wi_d    = wi_q - LEN_WIDTH'(1);
                  addr_d  = addr_q - ADDR_WIDTH'(1);
                  state_d = RD_REQ;
               end
            end else begin
               bc_d = bc_q - BC_W'(1);
               if (sr_msb) state_d = STREAM;
            end
         end
         STREAM: begin
`ifdef ECM_K_PREFETCH_EN
            if (pf_pend_q && mem_rd_val) begin
               pf_d      = mem_rd_data;
               pf_full_d = 1'b1;
               pf_pend_d = 1'b0;
            end
            if (pf_issue) begin
               pf_pend_d = 1'b1;
               addr_d    = addr_q - ADDR_WIDTH'(1);
            end
`endif
            if (xfer) begin
               sr_d = {sr_q[WORD_WIDTH-2:0], 1'b0};
               if (bc_zero && wi_zero) begin
                  state_d = DONE;
               end else if (bc_zero) begin
                  wi_d = wi_q - LEN_WIDTH'(1);
`ifdef ECM_K_PREFETCH_EN
                  if (pf_full_q) begin
                     sr_d      = pf_q;
                     bc_d      = BC_MAX;
                     pf_full_d = 1'b0;
                  end else if (pf_pend_q && mem_rd_val) begin
                     sr_d      = mem_rd_data;
                     bc_d      = BC_MAX;
                     pf_full_d = 1'b0;
                  end else if (pf_pend_q) begin
                     state_d = RD_WAIT;
                  end else begin
                     addr_d  = addr_q - ADDR_WIDTH'(1);
                     state_d = RD_REQ;
                  end
`else
                  addr_d  = addr_q - ADDR_WIDTH'(1);
                  state_d = RD_REQ;
`endif
               end else begin
                  bc_d = bc_q - BC_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef ECM_K_PREFETCH_EN
      rd_en_d = (state_d == RD_REQ) || pf_issue;
`else
      rd_en_d = (state_d == RD_REQ);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bc_q    <= '0;
         wi_q    <= '0;
         addr_q  <= '0;
         found_q <= 1'b0;
         err_q   <= 1'b0;
         rd_en_q <= 1'b0;
`ifdef ECM_K_PREFETCH_EN
         pf_full_q <= 1'b0;
         pf_pend_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bc_q    <= bc_d;
         wi_q    <= wi_d;
         addr_q  <= addr_d;
         found_q <= found_d;
         err_q   <= err_d;
         rd_en_q <= rd_en_d;
`ifdef ECM_K_PREFETCH_EN
         pf_full_q <= pf_full_d;
         pf_pend_q <= pf_pend_d;
`endif
      end
      sr_q <= sr_d;
`ifdef ECM_K_PREFETCH_EN
      pf_q <= pf_d;
`endif
   end

   // Data-path bits are gated so every output reads 0 outside STREAM.
   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign mem_rd_en = rd_en_q;
   assign mem_addr  = addr_q;
   assign k_val     = (state_q == STREAM);
   assign k_bit     = k_val && sr_msb;
   assign k_last    = k_val && bc_zero && wi_zero;

endmodule

// File: tb/tb_ecm_k_streamer.sv
// Randomized bench for ecm_k_streamer: SRAM model, ladder-side k_req driver and a bit-list reference model.
module tb_ecm_k_streamer;
   localparam int WW = 32;
   localparam int AW = 10;
   localparam int LW = 4;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] k_len_words;
   logic          busy, done, err, mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_rd_data;
   logic          mem_rd_val;
   logic          k_req;
   logic          k_val, k_bit, k_last;

   ecm_k_streamer #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .k_len_words(k_len_words),
      .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data), .mem_rd_val(mem_rd_val), .k_req(k_req),
      .k_val(k_val), .k_bit(k_bit), .k_last(k_last)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // SRAM model: lat extra cycles beyond the minimum one-cycle response.
   logic [WW-1:0] mem [0:(1<<AW)-1];
   int            lat = 0;
   int            cnt = 0;
   logic [AW-1:0] paddr;
   logic [AW-1:0] rdq[$];

   initial begin
      mem_rd_val  = 1'b0;
      mem_rd_data = '0;
   end

   always @(posedge clk) begin
      mem_rd_val <= 1'b0;
      if (mem_rd_en) begin
         rdq.push_back(mem_addr);
         if (lat == 0) begin
            mem_rd_val  <= 1'b1;
            mem_rd_data <= mem[mem_addr];
         end else begin
            cnt   <= lat;
            paddr <= mem_addr;
         end
      end else if (cnt != 0) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            mem_rd_val  <= 1'b1;
            mem_rd_data <= mem[paddr];
         end
      end
   end

   // Ladder-side observation
   logic obs_bit[$];
   logic obs_last[$];
   int   done_cnt, unstable, cur_gap, max_gap, hold_cnt;
   logic err_at_done, kval_seen, prev_hold, prev_bit, prev_last;
   int   kmode = 0;

   always @(negedge clk) begin
      if (k_val && k_req) begin
         obs_bit.push_back(k_bit);
         obs_last.push_back(k_last);
      end
      if (prev_hold && k_val && (k_bit !== prev_bit || k_last !== prev_last)) unstable++;
      prev_hold = k_val && !k_req;
      prev_bit  = k_bit;
      prev_last = k_last;
      if (done) begin
         done_cnt++;
         err_at_done = err;
      end
      if (k_val) begin
         if (cur_gap > max_gap) max_gap = cur_gap;
         cur_gap   = 0;
         kval_seen = 1'b1;
      end else if (kval_seen) begin
         cur_gap++;
      end
   end

   always @(posedge clk) begin
      #1;
      case (kmode)
         0: k_req = 1'b1;
         1: k_req = 1'($urandom_range(0, 1));
         default: begin
            k_req = kval_seen && (hold_cnt >= 10);
            if (kval_seen) hold_cnt++;
         end
      endcase
   end

   logic [WW-1:0] jw [16];
   int            job = 0;

   task automatic clear_obs();
      obs_bit.delete();
      obs_last.delete();
      rdq.delete();
      done_cnt = 0; unstable = 0; cur_gap = 0; max_gap = 0; hold_cnt = 0;
      err_at_done = 1'b0; kval_seen = 1'b0; prev_hold = 1'b0;
   endtask

   task automatic run_job(input int len, input logic [AW-1:0] base, input int l, input int km);
      logic          eb[$];
      bit            found;
      logic          exp_err;
      logic [AW-1:0] a;
      int            nc, nb;
      eb = {};
      found = 0;
      for (int w = len - 1; w >= 0; w--)
         for (int b = WW - 1; b >= 0; b--) begin
            if (found) eb.push_back(jw[w][b]);
            else if (jw[w][b]) found = 1;
         end
      exp_err = (eb.size() == 0);
      for (int w = 0; w < len; w++) begin
         a = base + AW'(w);
         mem[a] = jw[w];
      end
      job++;
      @(posedge clk); #1;
      lat = l; kmode = km;
      clear_obs();
      base_addr = base; k_len_words = LW'(len); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; base_addr = AW'($urandom); k_len_words = LW'($urandom);
      @(negedge clk);
      chk($sformatf("j%0d err_on_start", job), err, (len == 0));
      nc = 0;
      while (done_cnt == 0 && nc < 3000) begin
         @(negedge clk);
         nc++;
      end
      chk($sformatf("j%0d timeout", job), (done_cnt == 0), 0);
      if (done_cnt == 0) begin
         rst = 1'b1; repeat (2) @(posedge clk); #1; rst = 1'b0;
      end
      repeat (4) @(negedge clk);
      chk($sformatf("j%0d done_pulses", job), done_cnt, 1);
      chk($sformatf("j%0d err_at_done", job), err_at_done, exp_err);
      chk($sformatf("j%0d err_sticky", job), err, exp_err);
      chk($sformatf("j%0d busy_after", job), busy, 0);
      chk($sformatf("j%0d nreads", job), rdq.size(), len);
      for (int j = 0; j < rdq.size() && j < len; j++) begin
         a = base + AW'(len - 1 - j);
         chk($sformatf("j%0d rd_addr%0d", job, j), rdq[j], a);
      end
      chk($sformatf("j%0d nbits", job), obs_bit.size(), eb.size());
      nb = (obs_bit.size() < eb.size()) ? obs_bit.size() : eb.size();
      for (int i = 0; i < nb; i++) begin
         chk($sformatf("j%0d bit%0d", job, i), obs_bit[i], eb[i]);
         chk($sformatf("j%0d last%0d", job, i), obs_last[i], (i == eb.size() - 1));
      end
      if (exp_err) chk($sformatf("j%0d kval_on_err", job), kval_seen, 0);
      chk($sformatf("j%0d stable", job), unstable, 0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " err"}, err, 0);
      chk({tag, " mem_rd_en"}, mem_rd_en, 0);
      chk({tag, " mem_addr"}, mem_addr, 0);
      chk({tag, " k_val"}, k_val, 0);
      chk({tag, " k_bit"}, k_bit, 0);
      chk({tag, " k_last"}, k_last, 0);
   endtask

   initial begin
      int len, nc;
      rst = 1'b1; start = 1'b0; base_addr = '0; k_len_words = '0; k_req = 1'b0;
      clear_obs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      jw[0] = 32'h0000_0005;
      run_job(1, 10'h040, 1, 0);
      jw[1] = 32'h0000_0001; jw[0] = 32'h8000_0000;
      run_job(2, 10'h100, 2, 1);
      jw[0] = 32'h0000_0001;
      run_job(1, 10'h010, 1, 1);
      jw[2] = '0; jw[1] = '0; jw[0] = '0;
      run_job(3, 10'h3FE, 0, 1);
      run_job(0, 10'h055, 0, 1);
      jw[0] = 32'hF000_0000;
      run_job(1, 10'h200, 1, 2);

      // Reset lands while the read is outstanding; the data arrives one cycle later.
      jw[0] = 32'h0000_0005;
      mem[10'h020] = jw[0];
      clear_obs();
      lat = 1; kmode = 0;
      @(posedge clk); #1;
      base_addr = 10'h020; k_len_words = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nc = 0;
      while (!mem_rd_en && nc < 20) begin
         @(negedge clk);
         nc++;
      end
      chk("rst_mid rd_seen", mem_rd_en, 1);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_idle_outputs("rst_mid");
      end
      chk("rst_mid no_xfer", obs_bit.size(), 0);
      run_job(1, 10'h020, 1, 1);

      // Word-boundary bubble with a one-cycle SRAM and continuous k_req
      jw[1] = 32'h8000_0001; jw[0] = $urandom;
      run_job(2, 10'h300, 0, 0);
`ifdef ECM_K_PREFETCH_EN
      chk("boundary gap", max_gap, 0);
`else
      chk("boundary gap>=2", (max_gap >= 2), 1);
`endif

      for (int r = 0; r < 30; r++) begin
         len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
         for (int w = 0; w < 4; w++) begin
            case ($urandom_range(0, 4))
               0: jw[w] = '0;
               1: jw[w] = $urandom >> $urandom_range(0, 31);
               2: jw[w] = 32'h1;
               default: jw[w] = $urandom;
            endcase
         end
         run_job(len, ($urandom_range(0, 3) == 0) ? AW'(10'h3FE) : AW'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 100000 cycles");
      $fatal(1);
   end
endmodule
